// File: rtl/mdu_alu.sv
// mdu_alu: registered integer execution unit for the MIPS execute stage.
//
// Single-cycle ALU operations return on aluout/zero with a one-cycle
// out_valid pulse the cycle after accept. Multiply/divide run iteratively
// (radix-2, WIDTH cycles) into internal HI/LO registers, which are read back
// with mfhi/mflo. While an MDU op runs, in_ready is low and the pipeline stalls.
//
// Handshake: an operation is consumed on a rising edge where
// in_valid & in_ready; operands and alucontrol are sampled only then. A
// held in_valid with in_ready low is not consumed and waits. out_valid is a
// single-cycle pulse per accepted ALU-class op; MDU ops never pulse it.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  operation offer / unit can accept this cycle
//   srca, srcb           operands (WIDTH bits)
//   alucontrol           4-bit operation select
//   out_valid            result pulse; aluout/zero hold when low
//   aluout, zero         result and (aluout == 0), registered together
//   mdu_busy             multiply/divide in progress (mirrors the FSM state)
//   ovf                  only when MDU_ALU_OVERFLOW_EN is defined: signed
//                        overflow of add/sub, aligned with out_valid
//
// Optional build macro: MDU_ALU_OVERFLOW_EN.
module mdu_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  output logic             out_valid,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             mdu_busy
`ifdef MDU_ALU_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [3:0] op_and   = 4'b0000;
  localparam logic [3:0] op_or    = 4'b0001;
  localparam logic [3:0] op_add   = 4'b0010;
  localparam logic [3:0] op_sll   = 4'b0011;
  localparam logic [3:0] op_mfhi  = 4'b0100;
  localparam logic [3:0] op_srl   = 4'b0101;
  localparam logic [3:0] op_sub   = 4'b0110;
  localparam logic [3:0] op_slt   = 4'b0111;
  localparam logic [3:0] op_sra   = 4'b1000;
  localparam logic [3:0] op_sltu  = 4'b1001;
  localparam logic [3:0] op_xor   = 4'b1010;
  localparam logic [3:0] op_nor   = 4'b1011;
  localparam logic [3:0] op_mflo  = 4'b1100;
  localparam logic [3:0] op_mult  = 4'b1101;
  localparam logic [3:0] op_multu = 4'b1110;
  localparam logic [3:0] op_div   = 4'b1111;

  // MDU operation kinds held for the duration of BUSY.
  localparam logic [1:0] k_mul  = 2'd0;
  localparam logic [1:0] k_div  = 2'd1;
  localparam logic [1:0] k_divz = 2'd2;

  typedef enum logic {s_idle, s_busy} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] p_hi, p_lo;   // mult: partial product / multiplier; div: remainder / dividend->quotient
  logic [WIDTH-1:0] opb_q;        // multiplicand or divisor magnitude
  logic [1:0]       kind_q;
  logic             neg_res_q;    // negate product, or quotient for div
  logic             neg_rem_q;    // remainder takes the dividend's sign
  logic [SHW-1:0]   cnt;

  logic accept, is_mdu, last;
  assign accept   = in_valid & in_ready;
  assign is_mdu   = (alucontrol == op_mult) || (alucontrol == op_multu) || (alucontrol == op_div);
  assign in_ready = (state == s_idle);
  assign mdu_busy = (state == s_busy);
  assign last     = (cnt == SHW'(WIDTH - 1));

  // ALU datapath
  logic [WIDTH-1:0] sum, diff, alu_res;
  assign sum  = srca + srcb;
  assign diff = srca - srcb;

  always_comb begin
    alu_res = '0;
    case (alucontrol)
      op_add:  alu_res = sum;
      op_sub:  alu_res = diff;
      op_and:  alu_res = srca & srcb;
      op_or:   alu_res = srca | srcb;
      op_xor:  alu_res = srca ^ srcb;
      op_nor:  alu_res = ~(srca | srcb);
      op_slt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      op_sltu: alu_res = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      op_sll:  alu_res = srca << srcb[SHW-1:0];
      op_srl:  alu_res = srca >> srcb[SHW-1:0];
      op_sra:  alu_res = $signed(srca) >>> srcb[SHW-1:0];
      op_mfhi: alu_res = hi_q;
      op_mflo: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

`ifdef MDU_ALU_OVERFLOW_EN
  logic alu_ovf;
  always_comb begin
    alu_ovf = 1'b0;
    if (alucontrol == op_add)
      alu_ovf = (srca[WIDTH-1] == srcb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
    else if (alucontrol == op_sub)
      alu_ovf = (srca[WIDTH-1] != srcb[WIDTH-1]) && (diff[WIDTH-1] != srca[WIDTH-1]);
  end
`endif

  // Operand magnitudes for the signed ops; the most-negative value maps to
  // itself, which is the correct unsigned magnitude.
  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = srca[WIDTH-1] ? -srca : srca;
  assign abs_b = srcb[WIDTH-1] ? -srcb : srcb;

  // One radix-2 step for each kind.
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] div_sub, it_hi, it_lo;
  logic             div_ge;
  always_comb begin
    mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_sh  = {p_hi, p_lo[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, opb_q});
    // When div_ge holds, the difference fits in WIDTH bits.
    div_sub = div_sh[WIDTH-1:0] - opb_q;
    if (kind_q == k_div) begin
      it_hi = div_ge ? div_sub : div_sh[WIDTH-1:0];
      it_lo = {p_lo[WIDTH-2:0], div_ge};
    end else begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], p_lo[WIDTH-1:1]};
    end
  end

  // Sign correction applied on the final step.
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic [WIDTH-1:0]   fin_hi, fin_lo;
  always_comb begin
    prod     = {it_hi, it_lo};
    prod_neg = -prod;
    case (kind_q)
      k_div: begin
        fin_lo = neg_res_q ? -it_lo : it_lo;
        fin_hi = neg_rem_q ? -it_hi : it_hi;
      end
      k_divz: begin
        fin_hi = p_hi;
        fin_lo = p_lo;
      end
      default: {fin_hi, fin_lo} = neg_res_q ? prod_neg : prod;
    endcase
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      s_idle: if (accept && is_mdu) state_nxt = s_busy;
      s_busy: if (last) state_nxt = s_idle;
      default: state_nxt = s_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= s_idle;
      hi_q      <= '0;
      lo_q      <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      opb_q     <= '0;
      kind_q    <= k_mul;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      aluout    <= '0;
      zero      <= 1'b1;
`ifdef MDU_ALU_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      if (accept) begin
        if (is_mdu) begin
          cnt       <= '0;
          p_hi      <= '0;
          neg_rem_q <= 1'b0;
          case (alucontrol)
            op_mult: begin
              kind_q    <= k_mul;
              p_lo      <= abs_b;
              opb_q     <= abs_a;
              neg_res_q <= srca[WIDTH-1] ^ srcb[WIDTH-1];
            end
            op_multu: begin
              kind_q    <= k_mul;
              p_lo      <= srcb;
              opb_q     <= srca;
              neg_res_q <= 1'b0;
            end
            default: begin
              if (srcb == '0) begin
                // Divide by zero: preload the fixed result, finish after one cycle.
                kind_q    <= k_divz;
                p_hi      <= srca;
                p_lo      <= '1;
                neg_res_q <= 1'b0;
                cnt       <= SHW'(WIDTH - 1);
              end else begin
                kind_q    <= k_div;
                p_lo      <= abs_a;
                opb_q     <= abs_b;
                neg_res_q <= srca[WIDTH-1] ^ srcb[WIDTH-1];
                neg_rem_q <= srca[WIDTH-1];
              end
            end
          endcase
        end else begin
          out_valid <= 1'b1;
          aluout    <= alu_res;
          zero      <= (alu_res == '0);
`ifdef MDU_ALU_OVERFLOW_EN
          ovf       <= alu_ovf;
`endif
        end
      end
      if (state == s_busy) begin
        p_hi <= it_hi;
        p_lo <= it_lo;
        cnt  <= cnt + SHW'(1);
        if (last) begin
          hi_q <= fin_hi;
          lo_q <= fin_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_alu.sv
// Testbench for mdu_alu (WIDTH=32): table of ALU vectors applied
// back-to-back, then hand-written multiply/divide, stall and abort sequences.
module tb_mdu_alu;
  localparam int W = 32;

  localparam logic [3:0] op_and   = 4'b0000;
  localparam logic [3:0] op_or    = 4'b0001;
  localparam logic [3:0] op_add   = 4'b0010;
  localparam logic [3:0] op_sll   = 4'b0011;
  localparam logic [3:0] op_mfhi  = 4'b0100;
  localparam logic [3:0] op_srl   = 4'b0101;
  localparam logic [3:0] op_sub   = 4'b0110;
  localparam logic [3:0] op_slt   = 4'b0111;
  localparam logic [3:0] op_sra   = 4'b1000;
  localparam logic [3:0] op_sltu  = 4'b1001;
  localparam logic [3:0] op_xor   = 4'b1010;
  localparam logic [3:0] op_nor   = 4'b1011;
  localparam logic [3:0] op_mflo  = 4'b1100;
  localparam logic [3:0] op_mult  = 4'b1101;
  localparam logic [3:0] op_multu = 4'b1110;
  localparam logic [3:0] op_div   = 4'b1111;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] srca, srcb;
  logic [3:0]   alucontrol;
  logic         out_valid;
  logic [W-1:0] aluout;
  logic         zero;
  logic         mdu_busy;
`ifdef MDU_ALU_OVERFLOW_EN
  logic         ovf;
`endif

  mdu_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .out_valid  (out_valid),
    .aluout     (aluout),
    .zero       (zero),
    .mdu_busy   (mdu_busy)
`ifdef MDU_ALU_OVERFLOW_EN
    ,
    .ovf        (ovf)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // driver: one ALU-class op, result checked the cycle after accept
  task automatic alu_op(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input string name);
    check({name, " ready"}, W'(in_ready), 1);
    alucontrol = ctrl; srca = a; srcb = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, " out_valid"}, W'(out_valid), 1);
    check({name, " aluout"}, aluout, exp);
    check({name, " zero"}, W'(zero), W'(exp == '0));
  endtask

  task automatic read_hilo(input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input string name);
    alu_op(op_mfhi, 32'h0, 32'h0, exp_hi, {name, " mfhi"});
    alu_op(op_mflo, 32'h0, 32'h0, exp_lo, {name, " mflo"});
  endtask

  // driver: one MDU op, counts cycles with in_ready low
  task automatic mdu_run(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_cycles, input string name);
    int n;
    logic pulse_seen;
    check({name, " ready"}, W'(in_ready), 1);
    alucontrol = ctrl; srca = a; srcb = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, " mdu_busy"}, W'(mdu_busy), 1);
    n = 0;
    pulse_seen = 1'b0;
    while (!in_ready && n < 200) begin
      if (out_valid) pulse_seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({name, " busy cycles"}, W'(n), W'(exp_cycles));
    check({name, " no out_valid"}, W'(pulse_seen), 0);
    check({name, " busy done"}, W'(mdu_busy), 0);
  endtask

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic         exp_ovf;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{op_add,  32'h00000007, 32'h00000009, 32'h00000010, 1'b0};
    vecs[1]  = '{op_sub,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
    vecs[2]  = '{op_sra,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0};
    vecs[3]  = '{op_slt,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[4]  = '{op_sltu, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[5]  = '{op_slt,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[6]  = '{op_sltu, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[7]  = '{op_and,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[8]  = '{op_or,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0};
    vecs[9]  = '{op_xor,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
    vecs[10] = '{op_nor,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b0};
    vecs[11] = '{op_nor,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{op_sll,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0};
    vecs[13] = '{op_sll,  32'h00000001, 32'h00000023, 32'h00000008, 1'b0};
    vecs[14] = '{op_srl,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0};
    vecs[15] = '{op_sra,  32'h40000000, 32'h00000004, 32'h04000000, 1'b0};
    vecs[16] = '{op_sub,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0};
    vecs[17] = '{op_add,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[18] = '{op_add,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    vecs[19] = '{op_sub,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    vecs[20] = '{op_add,  32'h00000001, 32'h00000001, 32'h00000002, 1'b0};
    vecs[21] = '{op_sub,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[22] = '{op_mfhi, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0};
    vecs[23] = '{op_mflo, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0};

    // reset
    rst = 1'b1; in_valid = 1'b0; srca = '0; srcb = '0; alucontrol = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset in_ready", W'(in_ready), 1);
    check("reset out_valid", W'(out_valid), 0);
    check("reset zero", W'(zero), 1);
    check("reset aluout", aluout, 0);
    check("reset mdu_busy", W'(mdu_busy), 0);

    // ALU table, back-to-back (in_valid held high across the loop)
    for (int i = 0; i < NV; i++) begin
      check($sformatf("vec%0d ready", i), W'(in_ready), 1);
      alucontrol = vecs[i].ctrl; srca = vecs[i].a; srcb = vecs[i].b; in_valid = 1'b1;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk); #1;
      check($sformatf("vec%0d out_valid", i), W'(out_valid), 1);
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check($sformatf("vec%0d aluout", i), aluout, e);
        check($sformatf("vec%0d zero", i), W'(zero), W'(e == '0));
      end
`ifdef MDU_ALU_OVERFLOW_EN
      check($sformatf("vec%0d ovf", i), W'(ovf), W'(vecs[i].exp_ovf));
`endif
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle out_valid", W'(out_valid), 0);
    check("idle aluout hold", aluout, vecs[NV-1].exp);

    // multiply
    mdu_run(op_mult, 32'hFFFFFFFE, 32'h00000003, 32, "mult");
    read_hilo(32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
    mdu_run(op_multu, 32'hFFFFFFFE, 32'h00000003, 32, "multu");
    read_hilo(32'h00000002, 32'hFFFFFFFA, "multu");
    mdu_run(op_multu, 32'h12345678, 32'h00000010, 32, "multu2");
    read_hilo(32'h00000001, 32'h23456780, "multu2");
    mdu_run(op_mult, 32'h7FFFFFFF, 32'h80000000, 32, "mult2");
    read_hilo(32'hC0000000, 32'h80000000, "mult2");

    // divide
    mdu_run(op_div, 32'hFFFFFFF9, 32'h00000002, 32, "div -7/2");
    read_hilo(32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
    mdu_run(op_div, 32'h80000000, 32'hFFFFFFFF, 32, "div min/-1");
    read_hilo(32'h00000000, 32'h80000000, "div min/-1");
    mdu_run(op_div, 32'h00000005, 32'h00000000, 1, "div 5/0");
    read_hilo(32'h00000005, 32'hFFFFFFFF, "div 5/0");
    mdu_run(op_div, 32'd100, 32'd7, 32, "div 100/7");
    read_hilo(32'd2, 32'd14, "div 100/7");
    mdu_run(op_div, 32'd7, 32'hFFFFFFFE, 32, "div 7/-2");
    read_hilo(32'd1, 32'hFFFFFFFD, "div 7/-2");

    // stall: add held through a multu, consumed exactly once afterwards
    begin
      int n;
      logic pulse_seen;
      alucontrol = op_multu; srca = 32'hFFFFFFFF; srcb = 32'hFFFFFFFF; in_valid = 1'b1;
      @(posedge clk); #1;
      alucontrol = op_add; srca = 32'h7; srcb = 32'h9;
      n = 0;
      pulse_seen = 1'b0;
      while (!in_ready && n < 200) begin
        if (out_valid) pulse_seen = 1'b1;
        @(posedge clk); #1;
        n++;
      end
      check("stall busy cycles", W'(n), 32);
      check("stall no early accept", W'(pulse_seen), 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("stall add out_valid", W'(out_valid), 1);
      check("stall add aluout", aluout, 32'h10);
      @(posedge clk); #1;
      check("stall add once", W'(out_valid), 0);
      read_hilo(32'hFFFFFFFE, 32'h00000001, "stall multu");
    end

    // abort: rst at cycle 10 of a mult
    alucontrol = op_mult; srca = 32'hFFFFFFFE; srcb = 32'h3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort busy before rst", W'(mdu_busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort mdu_busy", W'(mdu_busy), 0);
    check("abort in_ready", W'(in_ready), 1);
    check("abort out_valid", W'(out_valid), 0);
    read_hilo(32'h0, 32'h0, "abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
